// File: rtl/clk_div_ctrl_pkg.sv
// Shared definitions for the clock-divider ratio sequencer.
//   NUM_REQ   : number of ratio requesters served by the arbiter.
//   state_e   : sequencer FSM states.
//   is_bypass : true for ratios that run the divider in bypass (0 or 1).
package clk_div_ctrl_pkg;

   localparam int unsigned NUM_REQ = 2;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      LOAD,
      RELOCK,
      DONE
   } state_e;

   function automatic logic is_bypass(input int unsigned ratio);
      return (ratio <= 1);
   endfunction

endpackage

// File: rtl/clk_div_ratio_ctrl_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   i_clk, i_rst : clock and synchronous active-high reset
//   i_valid      : per-requester request
//   i_advance    : current grant was accepted; hand priority to the other requester
//   o_grant      : one-hot grant (zero when nothing is valid)
//   o_grant_id   : index of the granted requester
module rr_arb2
   import clk_div_ctrl_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic               i_advance,
   output logic [NUM_REQ-1:0] o_grant,
   output logic               o_grant_id
);

   // Requester that wins a tie; reset favours requester 0.
   logic ptr_q;

   always_comb begin
      o_grant    = '0;
      o_grant_id = ptr_q;
      unique case (i_valid)
         2'b01: begin
            o_grant    = 2'b01;
            o_grant_id = 1'b0;
         end
         2'b10: begin
            o_grant    = 2'b10;
            o_grant_id = 1'b1;
         end
         2'b11: begin
            o_grant    = ptr_q ? 2'b10 : 2'b01;
            o_grant_id = ptr_q;
         end
         default: begin
            o_grant    = '0;
            o_grant_id = ptr_q;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr_q <= 1'b0;
      end else if (i_advance) begin
         ptr_q <= ~o_grant_id;
      end
   end

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// Clock-divider ratio sequencer. Arbitrates ratio-change requests from two requesters and
// applies each one glitch-safely: gate the divider, settle, load the ratio, re-enable and
// wait for re-lock, then pulse o_done.
// Optional feature (macro CLK_DIV_RATIO_CTRL_RANGE_CHK_EN): adds parameter MAX_RATIO and
// output o_err; out-of-range requests complete immediately with o_err and are not applied.
// Ports:
//   i_clk, i_rst              : reference clock, synchronous active-high reset
//   i_req_valid / o_req_ready : per-requester valid/ready handshake
//   i_req_ratio0/1            : requested ratios
//   o_div_ratio, o_clk_en     : ratio and clock enable driven to the divider
//   o_busy                    : sequencer not idle
//   o_done, o_done_id         : completion pulse and the requester it belongs to
//   o_err                     : (optional) completion was a rejected out-of-range ratio
module clk_div_ratio_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int unsigned RATIO_WIDTH   = 6,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned RST_RATIO     = 1
`ifdef CLK_DIV_RATIO_CTRL_RANGE_CHK_EN
   ,
   parameter int unsigned MAX_RATIO     = 32
`endif
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [NUM_REQ-1:0]     i_req_valid,
   input  logic [RATIO_WIDTH-1:0] i_req_ratio0,
   input  logic [RATIO_WIDTH-1:0] i_req_ratio1,
   output logic [NUM_REQ-1:0]     o_req_ready,
   output logic [RATIO_WIDTH-1:0] o_div_ratio,
   output logic                   o_clk_en,
   output logic                   o_busy,
   output logic                   o_done,
`ifdef CLK_DIV_RATIO_CTRL_RANGE_CHK_EN
   output logic                   o_err,
`endif
   output logic                   o_done_id
);

   // One counter serves both the settle and the re-lock wait; it must hold 2*(2^W-1)-1.
   localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned CntW    = (SettleW > RATIO_WIDTH + 1) ? SettleW : RATIO_WIDTH + 1;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [CntW-1:0]        relock_last;
   logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
   logic [RATIO_WIDTH-1:0] new_ratio_q, new_ratio_d;
   logic [RATIO_WIDTH-1:0] acc_ratio;
   logic                   clk_en_q, clk_en_d;
   logic                   cur_id_q, cur_id_d;
   logic [NUM_REQ-1:0]     grant;
   logic                   grant_id;
   logic                   idle;
   logic                   accept;
`ifdef CLK_DIV_RATIO_CTRL_RANGE_CHK_EN
   logic                   err_q, err_d;
`endif

   assign idle        = (state_q == IDLE);
   assign o_req_ready = idle ? grant : '0;
   assign accept      = |(i_req_valid & o_req_ready);
   assign acc_ratio   = grant_id ? i_req_ratio1 : i_req_ratio0;

   rr_arb2 u_arb (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_valid    (i_req_valid),
      .i_advance  (accept),
      .o_grant    (grant),
      .o_grant_id (grant_id)
   );

   // Last RELOCK count value: N-1 with N = 2*ratio, or N = 1 in bypass.
   always_comb begin
      if (is_bypass(32'(new_ratio_q))) begin
         relock_last = '0;
      end else begin
         relock_last = (CntW'(new_ratio_q) << 1) - CntW'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ratio_d     = ratio_q;
      new_ratio_d = new_ratio_q;
      clk_en_d    = clk_en_q;
      cur_id_d    = cur_id_q;
`ifdef CLK_DIV_RATIO_CTRL_RANGE_CHK_EN
      err_d       = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               new_ratio_d = acc_ratio;
               cur_id_d    = grant_id;
               cnt_d       = '0;
`ifdef CLK_DIV_RATIO_CTRL_RANGE_CHK_EN
               err_d       = 1'b0;
               if (32'(acc_ratio) > MAX_RATIO) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else
`endif
               if (acc_ratio == ratio_q) begin
                  // Nothing to change: complete without gating the divider.
                  state_d = DONE;
               end else begin
                  clk_en_d = 1'b0;
                  state_d  = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
               // Ratio register updates on the edge into LOAD, while the enable is still low.
               ratio_d = new_ratio_q;
               cnt_d   = '0;
               state_d = LOAD;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         LOAD: begin
            clk_en_d = 1'b1;
            cnt_d    = '0;
            state_d  = RELOCK;
         end
         RELOCK: begin
            if (cnt_q == relock_last) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ratio_q     <= RATIO_WIDTH'(RST_RATIO);
         new_ratio_q <= RATIO_WIDTH'(RST_RATIO);
         clk_en_q    <= 1'b1;
         cur_id_q    <= 1'b0;
`ifdef CLK_DIV_RATIO_CTRL_RANGE_CHK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ratio_q     <= ratio_d;
         new_ratio_q <= new_ratio_d;
         clk_en_q    <= clk_en_d;
         cur_id_q    <= cur_id_d;
`ifdef CLK_DIV_RATIO_CTRL_RANGE_CHK_EN
         err_q       <= err_d;
`endif
      end
   end

   assign o_div_ratio = ratio_q;
   assign o_clk_en    = clk_en_q;
   assign o_busy      = ~idle;
   assign o_done      = (state_q == DONE);
   assign o_done_id   = o_done & cur_id_q;
`ifdef CLK_DIV_RATIO_CTRL_RANGE_CHK_EN
   assign o_err       = o_done & err_q;
`endif

endmodule

// File: doc/clk_div_ratio_ctrl.md
Name: clk_div_ratio_ctrl

Overview:
Sequencer that owns the clock divider's ratio and enable inputs and applies ratio changes glitch-safely. Two requesters (e.g. the register file and the low-power manager) submit new ratios over valid/ready. A round-robin arbiter picks one request. An FSM then gates the divider off, settles, loads the new ratio, re-enables and waits for re-lock before signalling completion.

Parameters:
RATIO_WIDTH, 6, width of the divide ratio (matches the divider).
SETTLE_CYCLES, 4, cycles the divider enable stays low before a new ratio is loaded; must be ≥1.
RST_RATIO, 1, ratio driven out of reset (0/1 = bypass).

Ports:
i_clk  in  1  reference clock; same clock as the divider's reference.
i_rst  in  1  synchronous, active-high reset.
i_req_valid  in  2  per-requester request valid; bit0 = requester 0.
i_req_ratio0  in  RATIO_WIDTH  ratio requested by requester 0.
i_req_ratio1  in  RATIO_WIDTH  ratio requested by requester 1.
o_req_ready  out  2  per-requester ready; one-hot or zero.
o_div_ratio  out  RATIO_WIDTH  ratio to the divider.
o_clk_en  out  1  clock enable to the divider.
o_busy  out  1  high in any state other than IDLE.
o_done  out  1  one-cycle pulse when a request completes.
o_done_id  out  1  requester index for the current o_done.

Behaviour:
- Reset values (held while i_rst=1, applied on a clock edge): o_div_ratio=RST_RATIO, o_clk_en=1, o_req_ready=0, o_busy=0, o_done=0, o_done_id=0, FSM=IDLE, round-robin pointer favours requester 0.
- Handshake: a transfer occurs when i_req_valid[i] & o_req_ready[i]. o_req_ready is combinational and is high only in IDLE, only for the arbitration winner. A valid that is not accepted must hold its ratio stable.
- Arbiter: round-robin.
  - If only one valid is high, that requester wins.
  - If both are high, the requester not served last wins. After each accept the pointer moves to the other requester.
- On accept, the accepted ratio and id are captured into registers (new_ratio, cur_id).
- FSM states:
  - IDLE: accept a request. If new_ratio == o_div_ratio, go to DONE (no gating). Otherwise go to DRAIN.
  - DRAIN: o_clk_en=0. Counter runs 0..SETTLE_CYCLES-1, then go to LOAD.
  - LOAD: one cycle. o_div_ratio<=new_ratio; o_clk_en stays 0.
  - RELOCK: o_clk_en=1. Wait N cycles, N = 2*new_ratio for new_ratio ≥2 and N=1 for new_ratio 0/1 (bypass). The counter is RATIO_WIDTH+1 bits wide, so ratio 63 gives 126 without overflow. Then go to DONE.
  - DONE: o_done=1 for exactly one cycle and o_done_id=cur_id. Return to IDLE. No accept in this cycle.
- Latency (accept at cycle T, changing ratio):
  - o_clk_en falls at T+1.
  - o_div_ratio changes at T+1+SETTLE_CYCLES.
  - o_clk_en rises at T+2+SETTLE_CYCLES.
  - o_done at T+2+SETTLE_CYCLES+N.
- Same-ratio request: o_done at T+1. o_clk_en never drops.
- Invariant: o_div_ratio changes only while o_clk_en=0.
- Reset mid-operation: on the next edge, all outputs return to reset values regardless of state. An in-flight request is dropped with no o_done.
- Requests arriving while busy are held off (ready=0). They are not queued internally.

Optional Feature:
- Macro: CLK_DIV_RATIO_CTRL_RANGE_CHK_EN. Adds parameter MAX_RATIO (default 32) and output o_err (1 bit, reset 0).
- With the macro: an accepted request with ratio > MAX_RATIO goes straight to DONE. o_div_ratio and o_clk_en are untouched, and o_err=1 in the same cycle as o_done.
- Without the macro: o_err and MAX_RATIO do not exist, and every ratio is applied.

Decomposition:
- Shared package clk_div_ctrl_pkg holds:
  - FSM state enum {IDLE, DRAIN, LOAD, RELOCK, DONE}.
  - Requester count constant NUM_REQ=2.
  - Bypass predicate (ratio ≤1) as a function.
- One sub-module: rr_arb2, a 2-way round-robin arbiter. Inputs: valid, advance. Outputs: grant (one-hot), grant_id. It holds its own pointer register.

Test Plan:
- Reset → o_div_ratio=1, o_clk_en=1, o_busy=0. Hold i_rst 3 cycles mid-RELOCK and confirm the same values with no o_done.
- SETTLE_CYCLES=4, current ratio 1, req0 ratio 8 accepted at T → o_clk_en low at T+1..T+5, o_div_ratio=8 at T+5, o_clk_en high at T+6, o_done with id 0 at T+22.
- Both valid in IDLE, last served = 0 → req1 granted. Back-to-back requests alternate grants 1,0,1 with no requester starved.
- Request ratio equal to current (8) → o_done at T+1, o_clk_en never deasserts.
- Ratio 63, then ratio 0 → RELOCK 126 cycles, then 1 cycle. Check for no counter wrap.
- With CLK_DIV_RATIO_CTRL_RANGE_CHK_EN and MAX_RATIO=32, request ratio 40 → o_done and o_err pulse at T+1, o_div_ratio unchanged.
